prio_arbiter: RTL
=================

# prio_arbiter

Parametrised, registered priority arbiter: the sequential successor to the combinational if/else priority selector. N request lines compete for one resource. The winner is chosen by an if/else-style priority chain and held until it releases. A hold-limit counter forces preemption so that a single requester cannot starve the others. It sits between request sources (bus masters, channel FSMs) and a shared sink.

## Interface
- N, 4, number of requesters; legal range 2..16
- MAX_HOLD, 8, maximum consecutive grant cycles while others are pending; legal range 1..255
- IW (localparam), $clog2(N), index width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  request vector; bit i = requester i
- gnt  output  N  registered grant; one-hot or all-zero
- gnt_valid  output  1  high when gnt != 0
- gnt_idx  output  IW  index of the current owner; 0 when idle
- preempt  output  1  one-cycle pulse on the first grant cycle after a forced hand-over

## Operation
- State machine with two states: IDLE (no owner) and BUSY (owner held in a register). A saturating hold counter cnt is 8 bits wide.
- winner(v): lowest set index of v (bit 0 is highest priority); undefined when v == 0, never used in that case.
- IDLE:
  - req != 0 -> BUSY, owner = winner(req), cnt = 1.
  - Otherwise stay in IDLE.
- BUSY, owner released (req[owner] == 0):
  - If req != 0 -> owner = winner(req), cnt = 1, stay in BUSY. The hand-over has no idle gap.
  - Otherwise -> IDLE.
- BUSY, owner still requesting, cnt == MAX_HOLD, and (req with bit owner cleared) != 0:
  - owner = winner(req with bit owner cleared), cnt = 1, preempt = 1 for the next cycle.
- BUSY, owner still requesting, all other cases:
  - Owner keeps the grant.
  - cnt = min(cnt + 1, MAX_HOLD).
  - A lone requester is never preempted.
- A higher-priority request arriving mid-hold does not preempt. It waits for release or timeout.
- gnt is decoded from owner and registered; it is zero in IDLE. gnt_idx equals owner in BUSY and 0 in IDLE.

## Timing
- All outputs are registered; there is no combinational path from req to any output.
- Grant latency: req sampled at rising edge k -> gnt valid after edge k.
- Release latency: owner's req sampled low at edge k -> gnt changes or clears after edge k.
- Under contention, an owner holds the grant for exactly MAX_HOLD cycles.
- preempt is high for exactly one cycle and is aligned with the new owner's first grant cycle.
- Reset values, taken immediately on rst_n low, including mid-grant:
  - state = IDLE, gnt = 0, gnt_valid = 0, gnt_idx = 0, preempt = 0, cnt = 0, rotation pointer = 0.
- First grant decision is made at the first rising edge after rst_n deasserts.
- Requests asserted and dropped between two edges are never seen.

## Configuration
- PRIO_ARB_RR_EN defined:
  - winner() searches round-robin, starting at pointer ptr and wrapping modulo N.
  - ptr = (new owner + 1) mod N, updated on every owner change.
  - The excluded owner at timeout is still skipped.
- PRIO_ARB_RR_EN undefined:
  - Fixed priority with bit 0 highest.
  - No pointer register is synthesised.

## Test plan
Benches use N=4, MAX_HOLD=3.
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_idx=0, preempt=0. Release rst_n -> after the next edge, gnt=4'b0001, gnt_idx=0.
- Reset mid-grant: gnt=4'b0100 held, rst_n pulled low between edges -> all outputs are 0 immediately, before any clock edge.
- Priority/no-preempt: req=4'b1100 -> gnt=4'b0100, idx=2. Change req to 4'b1101 -> gnt stays 4'b0100 for 3 total cycles, then becomes 4'b0001 with preempt=1 for one cycle.
- Hand-over: owner 0 drops while req=4'b1010 -> the next cycle gives gnt=4'b0010 with no zero cycle and preempt=0. Then req=0 -> gnt=0 one cycle later.
- Timeout, fixed priority: constant req=4'b0011 -> gnt pattern 0001 ×3, 0010 ×3, 0001 ×3, …; preempt pulses at each switch.
- Lone requester: req=4'b0100 for 20 cycles -> gnt=4'b0100 throughout, preempt never asserts.
- Round-robin (PRIO_ARB_RR_EN): constant req=4'b1111 -> grants 0001, 0010, 0100, 1000, 0001, each for 3 cycles.

Source files
------------

// File: rtl/prio_arbiter.sv
// Registered priority arbiter with hold-limit preemption.
// Optional round-robin search enabled by defining PRIO_ARB_RR_EN.
module prio_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          preempt_d;
    logic          take_d;
    logic [N-1:0]  gnt_d;
    logic [N-1:0]  others;
    logic [IW-1:0] start;

    // First set bit of v, scanning upward from start and wrapping modulo N.
    function automatic logic [IW-1:0] winner(input logic [N-1:0] v, input logic [IW-1:0] from);
        logic [IW-1:0] w;
        logic [IW-1:0] i;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            i = IW'((int'(from) + k) % N);
            if (!found && v[i]) begin
                w     = i;
                found = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef PRIO_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
    always_comb begin
        ptr_d = ptr_q;
        if (take_d)
            ptr_d = (int'(owner_d) == N-1) ? '0 : owner_d + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    assign start = '0;
`endif

    always_comb begin
        others = req;
        others[owner_q] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        take_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d = BUSY;
                    owner_d = winner(req, start);
                    cnt_d   = 8'd1;
                    take_d  = 1'b1;
                end
            end
            BUSY: begin
                if (!req[owner_q]) begin
                    if (req != '0) begin
                        owner_d = winner(req, start);
                        cnt_d   = 8'd1;
                        take_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        cnt_d   = 8'd0;
                    end
                end else if (cnt_q == 8'(MAX_HOLD) && others != '0) begin
                    owner_d   = winner(others, start);
                    cnt_d     = 8'd1;
                    preempt_d = 1'b1;
                    take_d    = 1'b1;
                end else if (cnt_q < 8'(MAX_HOLD)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_dec
        assign gnt_d[i] = (state_d == BUSY) && (owner_d == IW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            cnt_q     <= 8'd0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_valid <= (state_d == BUSY);
            preempt   <= preempt_d;
        end
    end

    assign gnt_idx = owner_q;

endmodule
